// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract: one full-adder slice plus a carry flop, operands consumed LSB first.
// Latency: start edge plus WIDTH edges; done pulses the cycle after the WIDTH-th RUN edge.
// Backpressure: none; start is ignored while busy, and a start during the done cycle chains directly.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             v
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             cy;
    logic             sum_bit;
    logic             carry_bit;

    // The single full-adder slice.
    always_comb begin
        sum_bit   = a_sh[0] ^ b_sh[0] ^ cy;
        carry_bit = (a_sh[0] & b_sh[0]) | (cy & (a_sh[0] ^ b_sh[0]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            cy    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            c     <= 1'b0;
            v     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b ^ {WIDTH{sub}};
                        cy    <= cin ^ sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // The A register doubles as the result register: sum bits enter at
                    // the MSB as operand bits leave at the LSB.
                    a_sh <= {sum_bit, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    cy   <= carry_bit;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        s     <= {sum_bit, a_sh[WIDTH-1:1]};
                        c     <= carry_bit;
                        v     <= cy ^ carry_bit;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: an 8-bit instance and an exhaustively driven 2-bit instance.
module tb_serial_add_sub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, cin8, sub8;
    logic [7:0] a8, b8;
    logic       busy8, done8, c8, v8;
    logic [7:0] s8;
    logic       start2, cin2, sub2;
    logic [1:0] a2, b2;
    logic       busy2, done2, c2, v2;
    logic [1:0] s2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy8), .done(done8), .s(s8), .c(c8), .v(v8)
    );

    serial_add_sub #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
        .busy(busy2), .done(done2), .s(s2), .c(c2), .v(v2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: presents operands with start for exactly one edge.
    task automatic kick8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts);
        a8 = ta; b8 = tb; cin8 = tc; sub8 = ts; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // Runs from the negedge after the start edge until done; poke>=0 injects a stray start.
    task automatic finish8(input string tag, input logic [7:0] es, input logic ec, input logic ev,
                           input int poke);
        int n;
        int nb;
        logic [7:0] prev_s;
        n = 0; nb = 0; prev_s = s8;
        while (!done8 && n < 40) begin
            if (busy8) nb++;
            if (n == 3) chk({tag, "_hold"}, 32'(s8), 32'(prev_s));
            if (n == poke) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; sub8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start8 = 1'b0;
        chk({tag, "_lat"},  32'(n), 32'd8);
        chk({tag, "_busy"}, 32'(nb), 32'd8);
        chk({tag, "_s"},    32'(s8), 32'(es));
        chk({tag, "_c"},    32'(c8), 32'(ec));
        chk({tag, "_v"},    32'(v8), 32'(ev));
    endtask

    task automatic idle_check8(input string tag);
        @(negedge clk);
        chk({tag, "_done_drop"}, 32'(done8), 32'd0);
        chk({tag, "_busy_drop"}, 32'(busy8), 32'd0);
    endtask

    initial begin
        int seen;
        int n;
        logic [1:0] bb;
        logic       ci;
        logic [2:0] sum;
        logic       ev;

        rst_n = 1'b0;
        start8 = 1'bx; a8 = 'x; b8 = 'x; cin8 = 1'bx; sub8 = 1'bx;
        start2 = 1'bx; a2 = 'x; b2 = 'x; cin2 = 1'bx; sub2 = 1'bx;
        repeat (3) @(negedge clk);
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_s",    32'(s8),    32'd0);
        chk("rst_c",    32'(c8),    32'd0);
        chk("rst_v",    32'(v8),    32'd0);
        chk("rst2_s",   32'(s2),    32'd0);

        kick8(8'h3C, 8'h45, 1'b0, 1'b0);
        finish8("add3c45", 8'h81, 1'b0, 1'b1, -1);
        idle_check8("add3c45");

        kick8(8'hFF, 8'h00, 1'b1, 1'b0);
        finish8("addff00", 8'h00, 1'b1, 1'b0, -1);
        idle_check8("addff00");

        kick8(8'h10, 8'h20, 1'b0, 1'b1);
        finish8("sub1020", 8'hF0, 1'b0, 1'b0, -1);
        idle_check8("sub1020");

        kick8(8'h80, 8'h01, 1'b0, 1'b1);
        finish8("sub8001", 8'h7F, 1'b1, 1'b1, -1);
        idle_check8("sub8001");

        kick8(8'h05, 8'h02, 1'b1, 1'b1);
        finish8("sub0502", 8'h02, 1'b1, 1'b0, -1);
        idle_check8("sub0502");

        // Stray start mid-run with different operands must not disturb the result.
        kick8(8'h12, 8'h34, 1'b0, 1'b0);
        finish8("ignore", 8'h46, 1'b0, 1'b0, 3);
        idle_check8("ignore");

        // Start held into the done cycle chains the next operation without an idle cycle.
        kick8(8'h01, 8'h01, 1'b0, 1'b0);
        finish8("chain_a", 8'h02, 1'b0, 1'b0, -1);
        kick8(8'h7F, 8'h01, 1'b0, 1'b0);
        chk("chain_busy", 32'(busy8), 32'd1);
        chk("chain_done", 32'(done8), 32'd0);
        finish8("chain_b", 8'h80, 1'b0, 1'b1, -1);
        idle_check8("chain_b");

        // Reset at cycle 4 of RUN abandons the operation.
        kick8(8'hAA, 8'h55, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy8), 32'd0);
        chk("midrst_s",    32'(s8),    32'd0);
        chk("midrst_c",    32'(c8),    32'd0);
        chk("midrst_v",    32'(v8),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) seen++;
        end
        chk("midrst_nodone", 32'(seen), 32'd0);
        chk("midrst_s_after", 32'(s8), 32'd0);

        // Exhaustive 2-bit sweep against an independent reference.
        for (int k = 0; k < 64; k++) begin
            a2 = k[1:0]; b2 = k[3:2]; cin2 = k[4]; sub2 = k[5];
            bb  = sub2 ? ~b2 : b2;
            ci  = sub2 ? ~cin2 : cin2;
            sum = {1'b0, a2} + {1'b0, bb} + {2'b00, ci};
            ev  = (a2[1] == bb[1]) && (sum[1] != a2[1]);
            start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            n = 0;
            while (!done2 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("w2_%0d_lat", k), 32'(n),  32'd2);
            chk($sformatf("w2_%0d_s",   k), 32'(s2), 32'(sum[1:0]));
            chk($sformatf("w2_%0d_c",   k), 32'(c2), 32'(sum[2]));
            chk($sformatf("w2_%0d_v",   k), 32'(v2), 32'(ev));
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
